// File: rtl/tadc_tdc_ctrl.sv
// tadc_tdc_ctrl: ring-oscillator edge counter with windowed
// averaging and a valid/ack result handshake.
module tadc_tdc_ctrl #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int WIN_W   = 12,
  parameter int AVG_MAX = 3,
  localparam int CH_W   = $clog2(NCH),
  localparam int AVG_W  = $clog2(AVG_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic [AVG_W-1:0] avg_log2,
  input  logic [NCH-1:0]   osc_in,
  output logic [NCH-1:0]   osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overflow
);

  localparam int ACC_W = CNT_W + AVG_MAX;
  localparam int WI_W  = (AVG_MAX > 0) ? AVG_MAX : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    ACCUM,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       scnt;
  logic [CH_W-1:0]  ch;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] wcyc;
  logic [AVG_W-1:0] avg;
  logic [WI_W-1:0]  widx;
  logic [WI_W-1:0]  last_idx;
  logic [CNT_W-1:0] wcnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [NCH-1:0]   s1, s2, s3;
  logic [NCH-1:0]   rise;
  logic             hit;

  logic [CH_W-1:0]  ch_c;
  logic [WIN_W-1:0] win_c;
  logic [AVG_W-1:0] avg_c;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign hit  = rise[ch];

  assign ch_c  = (32'(ch_sel) >= NCH) ? '0 : ch_sel;
  assign win_c = (win_len == '0) ? WIN_W'(1) : win_len;
  assign avg_c = (avg_log2 > AVG_W'(AVG_MAX))
               ? AVG_W'(AVG_MAX) : avg_log2;
  assign accept = start && (!result_valid || result_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      scnt         <= '0;
      ch           <= '0;
      win          <= '0;
      wcyc         <= '0;
      avg          <= '0;
      widx         <= '0;
      last_idx     <= '0;
      wcnt         <= '0;
      acc          <= '0;
      ovf          <= 1'b0;
      osc_en       <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (result_ack)
        result_valid <= 1'b0;
      // abort outranks every transition, including ACCUM->DONE
      if (abort && state != IDLE) begin
        state  <= IDLE;
        busy   <= 1'b0;
        osc_en <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              ch           <= ch_c;
              win          <= win_c;
              avg          <= avg_c;
              last_idx     <= WI_W'((1 << avg_c) - 1);
              acc          <= '0;
              ovf          <= 1'b0;
              wcnt         <= '0;
              widx         <= '0;
              wcyc         <= '0;
              scnt         <= '0;
              result_valid <= 1'b0;
              osc_en       <= NCH'(1) << ch_c;
              busy         <= 1'b1;
              state        <= SETTLE;
            end
          end
          SETTLE: begin
            scnt <= scnt + 2'd1;
            if (scnt == 2'd3)
              state <= COUNT;
          end
          COUNT: begin
            if (hit) begin
              if (wcnt == CMAX)
                ovf <= 1'b1;
              else
                wcnt <= wcnt + 1'b1;
            end
            wcyc <= wcyc + 1'b1;
            if (wcyc == win - 1'b1)
              state <= ACCUM;
          end
          ACCUM: begin
            acc  <= acc + ACC_W'(wcnt);
            wcnt <= '0;
            wcyc <= '0;
            widx <= widx + 1'b1;
            if (widx == last_idx) begin
              osc_en <= '0;
              state  <= DONE;
            end else begin
              state <= COUNT;
            end
          end
          DONE: begin
            result       <= CNT_W'(acc >> avg);
            overflow     <= ovf;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tadc_tdc_ctrl.sv
// Directed bench for tadc_tdc_ctrl: a default instance and a
// narrow-counter / AVG_MAX=2 instance for saturation and clamping.
module tb_tadc_tdc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic        abort;
  logic [1:0]  ch_sel;
  logic [11:0] win_len;
  logic [1:0]  avg_log2;
  logic [3:0]  osc_in;
  logic        result_ack;

  logic [3:0]  osc_en_a, osc_en_b;
  logic        busy_a, busy_b;
  logic [15:0] result_a;
  logic [3:0]  result_b;
  logic        rv_a, rv_b;
  logic        ovf_a, ovf_b;

  int errs = 0;
  int checks = 0;

  logic       osc_wave = 1'b0;
  int         osc_half = 40;
  logic [1:0] osc_ch = 2'd0;

  tadc_tdc_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .ch_sel(ch_sel), .win_len(win_len), .avg_log2(avg_log2),
    .osc_in(osc_in), .osc_en(osc_en_a), .busy(busy_a),
    .result(result_a), .result_valid(rv_a),
    .result_ack(result_ack), .overflow(ovf_a)
  );

  tadc_tdc_ctrl #(.CNT_W(4), .AVG_MAX(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .ch_sel(ch_sel), .win_len(win_len), .avg_log2(avg_log2),
    .osc_in(osc_in), .osc_en(osc_en_b), .busy(busy_b),
    .result(result_b), .result_valid(rv_b),
    .result_ack(result_ack), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oscillator edges sit 3 ns off the 10 ns clock grid
  initial begin
    #3;
    forever #(osc_half) osc_wave = ~osc_wave;
  end

  always_comb osc_in = osc_wave ? (4'b0001 << osc_ch) : 4'b0000;

  task automatic do_start(input bit b, input logic [1:0] ch,
                          input logic [11:0] w,
                          input logic [1:0] a, input int half);
    osc_half = half;
    osc_ch   = ch;
    ch_sel   = ch;
    win_len  = w;
    avg_log2 = a;
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_valid(input bit b, input int maxc,
                            output int n);
    n = 0;
    while (n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (b ? rv_b : rv_a) break;
    end
  endtask

  task automatic ack_pulse();
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, rv_a, ovf_a, osc_en_a, result_a} !== '0) begin
      errs++;
      $display("FAIL reset_a: got busy=%b rv=%b ovf=%b en=%b res=%0d want all 0",
               busy_a, rv_a, ovf_a, osc_en_a, result_a);
    end
    checks++;
    if ({busy_b, rv_b, ovf_b, osc_en_b, result_b} !== '0) begin
      errs++;
      $display("FAIL reset_b: got busy=%b rv=%b ovf=%b en=%b res=%0d want all 0",
               busy_b, rv_b, ovf_b, osc_en_b, result_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    int en_bad;
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    checks++;
    if (busy_a !== 1'b1 || osc_en_a !== 4'b0010) begin
      errs++;
      $display("FAIL basic_rise: got busy=%b en=%b want 1 0010",
               busy_a, osc_en_a);
    end
    n = 0;
    en_bad = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n <= 68 && osc_en_a !== 4'b0010) en_bad++;
      if (n >= 69 && osc_en_a !== 4'b0000) en_bad++;
      if (rv_a) break;
    end
    checks++;
    if (n != 70) begin
      errs++;
      $display("FAIL basic_latency: got %0d want 70", n);
    end
    checks++;
    if (result_a !== 16'd8 || ovf_a !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: got %0d ovf=%b want 8 0",
               result_a, ovf_a);
    end
    checks++;
    if (en_bad != 0) begin
      errs++;
      $display("FAIL basic_osc_en: got %0d bad cycles want 0", en_bad);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errs++;
      $display("FAIL basic_busy_fall: got %b want 0", busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ack_pulse();
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, rv_a, ovf_a, osc_en_a, result_a} !== '0) begin
      errs++;
      $display("FAIL reset_mid: got busy=%b rv=%b ovf=%b en=%b res=%0d want all 0",
               busy_a, rv_a, ovf_a, osc_en_a, result_a);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    wait_valid(0, 200, n);
    checks++;
    if (n != 70 || result_a !== 16'd8) begin
      errs++;
      $display("FAIL reset_mid_restart: got lat=%0d res=%0d want 70 8",
               n, result_a);
    end
  endtask

  task automatic test_averaging();
    int n;
    ack_pulse();
    do_start(0, 2'd2, 12'd60, 2'd2, 40);
    checks++;
    if (osc_en_a !== 4'b0100) begin
      errs++;
      $display("FAIL avg_osc_en: got %b want 0100", osc_en_a);
    end
    wait_valid(0, 400, n);
    checks++;
    if (n != 249) begin
      errs++;
      $display("FAIL avg_latency: got %0d want 249", n);
    end
    checks++;
    if (result_a < 16'd7 || result_a > 16'd8 || ovf_a !== 1'b0) begin
      errs++;
      $display("FAIL avg_result: got %0d ovf=%b want 7..8 0",
               result_a, ovf_a);
    end
  endtask

  task automatic test_win_zero();
    int n;
    ack_pulse();
    do_start(0, 2'd1, 12'd0, 2'd0, 40);
    wait_valid(0, 50, n);
    checks++;
    if (n != 7) begin
      errs++;
      $display("FAIL win_zero_latency: got %0d want 7", n);
    end
  endtask

  task automatic test_handshake();
    int n;
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    checks++;
    if (busy_a !== 1'b0 || rv_a !== 1'b1) begin
      errs++;
      $display("FAIL hs_ignore: got busy=%b rv=%b want 0 1",
               busy_a, rv_a);
    end
    result_ack = 1'b1;
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    result_ack = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || rv_a !== 1'b0) begin
      errs++;
      $display("FAIL hs_accept: got busy=%b rv=%b want 1 0",
               busy_a, rv_a);
    end
    wait_valid(0, 200, n);
    checks++;
    if (n != 70 || result_a !== 16'd8) begin
      errs++;
      $display("FAIL hs_result: got lat=%0d res=%0d want 70 8",
               n, result_a);
    end
  endtask

  task automatic test_abort();
    ack_pulse();
    do_start(0, 2'd1, 12'd20, 2'd1, 40);
    repeat (29) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || osc_en_a !== 4'b0000) begin
      errs++;
      $display("FAIL abort_count: got busy=%b en=%b want 0 0000",
               busy_a, osc_en_a);
    end
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (result_a !== 16'd8 || rv_a !== 1'b0 || busy_a !== 1'b0) begin
      errs++;
      $display("FAIL abort_hold: got res=%0d rv=%b busy=%b want 8 0 0",
               result_a, rv_a, busy_a);
    end
    do_start(0, 2'd1, 12'd10, 2'd0, 40);
    repeat (14) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || osc_en_a !== 4'b0000) begin
      errs++;
      $display("FAIL abort_accum: got busy=%b en=%b want 0 0000",
               busy_a, osc_en_a);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rv_a !== 1'b0 || result_a !== 16'd8) begin
      errs++;
      $display("FAIL abort_accum_hold: got rv=%b res=%0d want 0 8",
               rv_a, result_a);
    end
  endtask

  task automatic test_start_abort();
    int n;
    abort = 1'b1;
    do_start(0, 2'd1, 12'd64, 2'd0, 40);
    abort = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errs++;
      $display("FAIL start_abort: got busy=%b want 1", busy_a);
    end
    wait_valid(0, 200, n);
    checks++;
    if (n != 70 || result_a !== 16'd8) begin
      errs++;
      $display("FAIL start_abort_result: got lat=%0d res=%0d want 70 8",
               n, result_a);
    end
  endtask

  task automatic test_saturation();
    int n;
    do_start(1, 2'd0, 12'd100, 2'd0, 20);
    wait_valid(1, 300, n);
    checks++;
    if (n != 106) begin
      errs++;
      $display("FAIL sat_latency: got %0d want 106", n);
    end
    checks++;
    if (result_b !== 4'd15 || ovf_b !== 1'b1) begin
      errs++;
      $display("FAIL sat_result: got %0d ovf=%b want 15 1",
               result_b, ovf_b);
    end
    ack_pulse();
    do_start(1, 2'd0, 12'd8, 2'd0, 20);
    wait_valid(1, 100, n);
    checks++;
    if (n != 14 || result_b !== 4'd2 || ovf_b !== 1'b0) begin
      errs++;
      $display("FAIL sat_clear: got lat=%0d res=%0d ovf=%b want 14 2 0",
               n, result_b, ovf_b);
    end
  endtask

  task automatic test_clamp();
    int n;
    ack_pulse();
    do_start(1, 2'd0, 12'd8, 2'd3, 20);
    wait_valid(1, 150, n);
    checks++;
    if (n != 41) begin
      errs++;
      $display("FAIL clamp_latency: got %0d want 41", n);
    end
    checks++;
    if (result_b !== 4'd2 || ovf_b !== 1'b0) begin
      errs++;
      $display("FAIL clamp_result: got %0d ovf=%b want 2 0",
               result_b, ovf_b);
    end
  endtask

  initial begin
    start_a    = 1'b0;
    start_b    = 1'b0;
    abort      = 1'b0;
    ch_sel     = 2'd0;
    win_len    = 12'd0;
    avg_log2   = 2'd0;
    result_ack = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_averaging();
    test_win_zero();
    test_handshake();
    test_abort();
    test_start_abort();
    test_saturation();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
